reg_campo_bcd: RTL

- Parametrised 2-digit BCD time/date field register; next generation of the per-field month/day/hour registers in the RTC controller.
- Holds one field value. User edits it with UP/DOWN while Modificando is high. Otherwise it reloads from the RTC read path when Actualizar is high.
- Adds features the per-field registers lacked: configurable range and reset value, edge-detected stepping, hold-to-auto-repeat, load validation, and a change strobe for RTC write-back.

---
 rtl/reg_campo_bcd.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/reg_campo_bcd.sv
// Two-digit BCD field register with key stepping, auto-repeat, validated loads and a change strobe.
// Optional macro REG_CAMPO_LIMITE_DIN_EN adds a dynamic upper bound input MAX_in with clamping.
module reg_campo_bcd #(
  parameter int MIN_VAL       = 1,
  parameter int MAX_VAL       = 12,
  parameter int RESET_VAL     = 1,
  parameter int HOLD_CYCLES   = 25000000,
  parameter int REPEAT_CYCLES = 5000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       UP,
  input  logic       DOWN,
  input  logic       Modificando,
  input  logic       Actualizar,
  input  logic [7:0] DATA_in,
`ifdef REG_CAMPO_LIMITE_DIN_EN
  input  logic [7:0] MAX_in,
`endif
  output logic [7:0] DATA_out,
  output logic       Cambio,
  output logic       Error_in
);

  // state  | meaning
  // IDLE   | no key held, waiting for a key press edge
  // HOLD   | first step taken, timing the hold delay
  // REPEAT | auto-repeat, one step every REPEAT_CYCLES
  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

  localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX);
  localparam logic [CW-1:0] HOLD_TC   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REPEAT_TC = CW'(REPEAT_CYCLES - 1);
  localparam logic [7:0] MIN_BCD   = 8'((MIN_VAL / 10) * 16 + MIN_VAL % 10);
  localparam logic [7:0] MAX_BCD   = 8'((MAX_VAL / 10) * 16 + MAX_VAL % 10);
  localparam logic [7:0] RESET_BCD = 8'((RESET_VAL / 10) * 16 + RESET_VAL % 10);
  localparam logic [7:0] MIN_BIN   = 8'(MIN_VAL);

  function automatic logic [7:0] bcd2bin(input logic [7:0] b);
    return ({4'd0, b[7:4]} * 8'd10) + {4'd0, b[3:0]};
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] b);
    if (b[3:0] >= 4'd9) return {b[7:4] + 4'd1, 4'd0};
    else                return {b[7:4], b[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] b);
    if (b[3:0] == 4'd0) return {b[7:4] - 4'd1, 4'd9};
    else                return {b[7:4], b[3:0] - 4'd1};
  endfunction

  state_t        state;
  logic [CW-1:0] cnt;
  logic          up_q, down_q, dir_up;

  logic       key_up, key_dn, press_up, press_dn, key_same;
  logic       step, step_up, load_req, in_ok;
  logic [7:0] max_bcd, max_bin, data_bin, in_bin, nxt_up, nxt_dn;

`ifdef REG_CAMPO_LIMITE_DIN_EN
  logic max_ok;
  // A malformed or too-small dynamic bound falls back to the static one.
  assign max_ok  = (MAX_in[7:4] <= 4'd9) && (MAX_in[3:0] <= 4'd9) && (bcd2bin(MAX_in) >= MIN_BIN);
  assign max_bcd = max_ok ? MAX_in : MAX_BCD;
`else
  assign max_bcd = MAX_BCD;
`endif

  assign max_bin  = bcd2bin(max_bcd);
  assign data_bin = bcd2bin(DATA_out);
  assign in_bin   = bcd2bin(DATA_in);
  assign in_ok    = (DATA_in[7:4] <= 4'd9) && (DATA_in[3:0] <= 4'd9) &&
                    (in_bin >= MIN_BIN) && (in_bin <= max_bin);
  assign load_req = ~Modificando & Actualizar;

  assign nxt_up = (data_bin >= max_bin) ? MIN_BCD : bcd_inc(DATA_out);
  assign nxt_dn = (data_bin <= MIN_BIN) ? max_bcd : bcd_dec(DATA_out);

  // Edges are taken on the decoded single-key signals so releasing one of two held keys counts as a press.
  assign key_up   = UP & ~DOWN;
  assign key_dn   = DOWN & ~UP;
  assign press_up = key_up & ~(up_q & ~down_q);
  assign press_dn = key_dn & ~(down_q & ~up_q);
  assign key_same = dir_up ? key_up : key_dn;

  always_comb begin
    step    = 1'b0;
    step_up = 1'b0;
    if (Modificando) begin
      case (state)
        IDLE: begin
          step    = press_up | press_dn;
          step_up = press_up;
        end
        HOLD: begin
          step    = key_same && (cnt == HOLD_TC);
          step_up = dir_up;
        end
        REPEAT: begin
          step    = key_same && (cnt == REPEAT_TC);
          step_up = dir_up;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      DATA_out <= RESET_BCD;
      Cambio   <= 1'b0;
      Error_in <= 1'b0;
      state    <= IDLE;
      cnt      <= '0;
      up_q     <= 1'b0;
      down_q   <= 1'b0;
      dir_up   <= 1'b0;
    end else begin
      up_q     <= UP;
      down_q   <= DOWN;
      Cambio   <= 1'b0;
      Error_in <= 1'b0;

      if (load_req) begin
        if (in_ok) DATA_out <= DATA_in;
        else       Error_in <= 1'b1;
      end else if (step) begin
        DATA_out <= step_up ? nxt_up : nxt_dn;
        Cambio   <= 1'b1;
      end
`ifdef REG_CAMPO_LIMITE_DIN_EN
      else if (data_bin > max_bin) begin
        DATA_out <= max_bcd;
        Cambio   <= 1'b1;
      end
`endif

      if (!Modificando) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (press_up | press_dn) begin
              state  <= HOLD;
              cnt    <= '0;
              dir_up <= press_up;
            end
          end
          HOLD: begin
            if (!key_same) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (cnt == HOLD_TC) begin
              state <= REPEAT;
              cnt   <= '0;
            end else if (cnt != {CW{1'b1}}) begin
              cnt <= cnt + 1'b1;
            end
          end
          REPEAT: begin
            if (!key_same) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (cnt == REPEAT_TC) begin
              cnt <= '0;
            end else if (cnt != {CW{1'b1}}) begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule
